// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   XLEN / INSTR_BYTES  - datapath width and fetch step
//   RV_NOP              - canonical RV32I nop encoding
//   fetch_entry_t       - {instr, pc} record held in the fetch queue
//   cnt_width()         - width of a counter that must hold 0..depth inclusive
package ifu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RV_NOP  = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Counters must represent the full value 'depth', hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned IFU_DEFAULT_DEPTH = 4;
    localparam int unsigned IFU_CNT_W         = $clog2(IFU_DEFAULT_DEPTH) + 1;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous Depth-entry FIFO of fetch_entry_t words.
//   clk_i, rst_ni   - clock, asynchronous active-low reset (clears storage too)
//   flush_i         - empties the queue; wins over push/pop in the same cycle
//   push_i, data_i  - enqueue (ignored when full unless a pop happens too)
//   pop_i, data_o   - dequeue; data_o always shows the head entry
//   count_o, full_o, empty_o - occupancy
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [ENTRY_W-1:0]          data_i,
    input  logic                        pop_i,
    output logic [ENTRY_W-1:0]          data_o,
    output logic [cnt_width(Depth)-1:0] count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = cnt_width(Depth);

    logic [ENTRY_W-1:0] mem_q [Depth];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage. Owns the fetch PC, issues sequential word requests
// to instruction memory, queues in-order responses tagged with their PC for decode, and
// flushes on branch/jump redirects while discarding responses still in flight.
//   clk_i, rst_ni                    - clock, asynchronous active-low reset
//   redirect_valid_i, redirect_pc_i  - taken branch/jump and its target (bits [1:0] ignored)
//   imem_req_valid_o/ready_i/addr_o  - request channel (addr = fetch PC)
//   imem_rsp_valid_i, imem_rsp_data_i - in-order responses, always accepted
//   dec_valid_o/ready_i/instr_o/pc_o - head of the fetch queue towards decode
//   fetch_pc_o                       - current fetch PC register
// Build option: define IFU_BYPASS_EN to let a response reach decode in the same cycle
// when the queue is empty and nothing is being dropped.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] dec_instr_o,
    output logic [31:0] dec_pc_o,
    output logic [31:0] fetch_pc_o
);

    localparam int unsigned CntW   = cnt_width(DEPTH);
    localparam logic [31:0] PcStep = 32'(INSTR_BYTES);

    logic            released_q;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;

    logic [CntW-1:0] fifo_count;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    fetch_entry_t    push_entry, head_entry;

    logic [CntW:0]   in_use;
    logic            credit_ok, req_fire, rsp_keep, rsp_drop, bypass_take;
    logic [31:0]     redirect_tgt;
    logic            unused_rpc_lsb;

    assign redirect_tgt   = {redirect_pc_i[31:2], 2'b00};
    assign unused_rpc_lsb = ^redirect_pc_i[1:0];

    // Credits cover both queued entries and every in-flight request, including ones that
    // will be dropped, so a kept response always finds room in the queue.
    assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit_ok = (in_use < (CntW + 1)'(DEPTH));

    assign imem_req_valid_o = released_q & ~redirect_valid_i & credit_ok;
    assign imem_req_addr_o  = fetch_pc_q;
    assign fetch_pc_o       = fetch_pc_q;
    assign req_fire         = imem_req_valid_o & imem_req_ready_i;

    assign rsp_keep = imem_rsp_valid_i & (drop_q == '0);
    assign rsp_drop = imem_rsp_valid_i & (drop_q != '0);

`ifdef IFU_BYPASS_EN
    logic bypass_valid;
    assign bypass_valid = fifo_empty & rsp_keep & ~redirect_valid_i;
    assign bypass_take  = bypass_valid & dec_ready_i;
    assign dec_valid_o  = ~fifo_empty | bypass_valid;
    assign dec_instr_o  = bypass_valid ? imem_rsp_data_i : head_entry.instr;
    assign dec_pc_o     = bypass_valid ? rsp_pc_q : head_entry.pc;
`else
    assign bypass_take  = 1'b0;
    assign dec_valid_o  = ~fifo_empty;
    assign dec_instr_o  = head_entry.instr;
    assign dec_pc_o     = head_entry.pc;
`endif

    assign fifo_pop   = ~fifo_empty & dec_ready_i;
    // A response in the redirect cycle belongs to the old path and is discarded.
    assign fifo_push  = rsp_keep & ~redirect_valid_i & ~bypass_take;
    assign push_entry = '{instr: imem_rsp_data_i, pc: rsp_pc_q};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid_i);
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            // No request can fire here, so everything still outstanding afterwards is stale.
            drop_d     = outstanding_q - CntW'(imem_rsp_valid_i);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + PcStep;
            if (rsp_keep) rsp_pc_d = rsp_pc_q + PcStep;
            if (rsp_drop) drop_d = drop_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            released_q    <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            released_q    <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .Depth (DEPTH)
    ) u_fetch_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_valid_i),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .data_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The credit check makes this impossible; firing means the accounting is broken.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(fifo_push && fifo_full && !fifo_pop))
        else $error("instr_fetch_unit: response arrived with fetch queue full");

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFU_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] fetch_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_ready_i (imem_req_ready),
        .imem_req_addr_o  (imem_req_addr),
        .imem_rsp_valid_i (imem_rsp_valid),
        .imem_rsp_data_i  (imem_rsp_data),
        .dec_valid_o      (dec_valid),
        .dec_ready_i      (dec_ready),
        .dec_instr_o      (dec_instr),
        .dec_pc_o         (dec_pc),
        .fetch_pc_o       (fetch_pc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_0013;
    endfunction

    // Reference model: requests in flight (oldest first) and the decode queue contents.
    typedef struct {
        logic [31:0] addr;
        int          cyc;
        bit          stale;
    } inflight_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    inflight_t   inflight[$];
    ent_t        mq[$];
    logic [31:0] mfpc;
    bit          released;
    int          cyc_n = 0;
    logic [31:0] fire_log[$];
    logic [31:0] deq_log[$];
    logic        samp_req_v;
    logic        samp_dec_v;

    task automatic do_reset();
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        dec_ready      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_fetch_pc", fetch_pc, RESET_PC);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
        inflight.delete();
        mq.delete();
        fire_log.delete();
        deq_log.delete();
        mfpc     = RESET_PC;
        released = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs in the low phase, check, update model, wait for next negedge.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy,
                         input bit rsp_en, input bit dready);
        bit        rsp_go, byp, exp_rv, exp_dv, fire, deq, take;
        ent_t      head, e;
        inflight_t f;
        rsp_go = 1'b0;
        if (rsp_en && inflight.size() > 0) rsp_go = (inflight[0].cyc < cyc_n);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        dec_ready      = dready;
        imem_rsp_valid = rsp_go;
        imem_rsp_data  = rsp_go ? memw(inflight[0].addr) : $urandom();
        #1;
        exp_rv = released && !redir && (inflight.size() + mq.size() < DEPTH);
        byp = 1'b0;
        if (Byp && rsp_go && mq.size() == 0 && !redir) byp = !inflight[0].stale;
        exp_dv = (mq.size() > 0) || byp;
        head.instr = '0;
        head.pc    = '0;
        if (mq.size() > 0) head = mq[0];
        else if (byp) begin
            head.instr = memw(inflight[0].addr);
            head.pc    = inflight[0].addr;
        end
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", imem_req_addr, mfpc);
        chk("fetch_pc", fetch_pc, mfpc);
        chk("dec_valid", 32'(dec_valid), 32'(exp_dv));
        if (exp_dv) begin
            chk("dec_pc", dec_pc, head.pc);
            chk("dec_instr", dec_instr, head.instr);
        end
        samp_req_v = imem_req_valid;
        samp_dec_v = dec_valid;
        fire = exp_rv && rdy;
        deq  = exp_dv && dready;
        take = 1'b0;
        if (deq) begin
            deq_log.push_back(head.pc);
            if (mq.size() > 0) void'(mq.pop_front());
            else take = 1'b1;
        end
        if (rsp_go) begin
            f = inflight.pop_front();
            if (!f.stale && !redir && !take) begin
                e.instr = memw(f.addr);
                e.pc    = f.addr;
                mq.push_back(e);
            end
        end
        if (redir) begin
            mq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            mfpc = {rpc[31:2], 2'b00};
        end
        if (fire) begin
            f.addr  = mfpc;
            f.cyc   = cyc_n;
            f.stale = 1'b0;
            inflight.push_back(f);
            fire_log.push_back(mfpc);
            mfpc = mfpc + 32'd4;
        end
        released = 1'b1;
        cyc_n++;
        @(negedge clk);
    endtask

    // Directed stream: ready memory with 1-cycle latency, decode always ready.
    typedef struct {
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        exp_req_v;
        logic [31:0] exp_addr;
        logic        exp_dec_v;
        logic [31:0] exp_dec_pc;
        logic [31:0] exp_dec_instr;
    } vec_t;
    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        int lat;
        lat = Byp ? 2 : 3;
        for (int r = 0; r < NV; r++) begin
            vecs[r].rsp_v         = (r >= 2);
            vecs[r].rsp_d         = (r >= 2) ? memw(32'(4 * (r - 2))) : 32'hDEAD_BEEF;
            vecs[r].exp_req_v     = (r >= 1);
            vecs[r].exp_addr      = (r >= 1) ? 32'(4 * (r - 1)) : RESET_PC;
            vecs[r].exp_dec_v     = (r >= lat);
            vecs[r].exp_dec_pc    = 32'(4 * (r - lat));
            vecs[r].exp_dec_instr = memw(32'(4 * (r - lat)));
        end

        do_reset();
        for (int r = 0; r < NV; r++) begin
            redirect_valid = 1'b0;
            imem_req_ready = 1'b1;
            dec_ready      = 1'b1;
            imem_rsp_valid = vecs[r].rsp_v;
            imem_rsp_data  = vecs[r].rsp_d;
            #1;
            chk($sformatf("tbl%0d_req_valid", r), 32'(imem_req_valid), 32'(vecs[r].exp_req_v));
            chk($sformatf("tbl%0d_req_addr", r), imem_req_addr, vecs[r].exp_addr);
            chk($sformatf("tbl%0d_dec_valid", r), 32'(dec_valid), 32'(vecs[r].exp_dec_v));
            if (vecs[r].exp_dec_v) begin
                chk($sformatf("tbl%0d_dec_pc", r), dec_pc, vecs[r].exp_dec_pc);
                chk($sformatf("tbl%0d_dec_instr", r), dec_instr, vecs[r].exp_dec_instr);
            end
            @(negedge clk);
        end

        // Decode stalled: exactly DEPTH requests, then drain in order.
        do_reset();
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("bp_fire_count", fire_log.size(), DEPTH);
        chk("bp_req_stalled", 32'(samp_req_v), 32'd0);
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("bp_drain_enough", 32'(deq_log.size() >= 8), 32'd1);
        if (deq_log.size() >= 8)
            for (int i = 0; i < 8; i++) chk($sformatf("bp_drain%0d", i), deq_log[i], 32'(4 * i));

        // Redirect with 3 requests in flight.
        do_reset();
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("rd_inflight", fire_log.size(), 32'd3);
        cycle(1'b1, 32'h0000_0103, 1'b1, 1'b0, 1'b1);
        chk("rd_req_blocked", 32'(samp_req_v), 32'd0);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("rd_next_addr", (fire_log.size() > 3) ? fire_log[3] : 32'hX, 32'h0000_0100);
        chk("rd_first_dec", (deq_log.size() > 0) ? deq_log[0] : 32'hX, 32'h0000_0100);

        // Redirect in the same cycle as a response, memory ready.
        do_reset();
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
        chk("rdr_req_blocked", 32'(samp_req_v), 32'd0);
        chk("rdr_fires", fire_log.size(), 32'd3);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("rdr_next_addr", (fire_log.size() > 3) ? fire_log[3] : 32'hX, 32'h0000_0200);
        chk("rdr_first_dec", (deq_log.size() > 0) ? deq_log[0] : 32'hX, 32'h0000_0200);

        // Back-to-back redirects, the second one wins.
        do_reset();
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_040A, 1'b1, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("b2b_next_addr", (fire_log.size() > 3) ? fire_log[3] : 32'hX, 32'h0000_0408);
        chk("b2b_first_dec", (deq_log.size() > 0) ? deq_log[0] : 32'hX, 32'h0000_0408);

        // Address wrap at the top of memory.
        do_reset();
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("wrap_enough", 32'(fire_log.size() >= 3 && deq_log.size() >= 3), 32'd1);
        if (fire_log.size() >= 3 && deq_log.size() >= 3) begin
            chk("wrap_a0", fire_log[0], 32'hFFFF_FFF8);
            chk("wrap_a1", fire_log[1], 32'hFFFF_FFFC);
            chk("wrap_a2", fire_log[2], 32'h0000_0000);
            chk("wrap_d2", deq_log[2], 32'h0000_0000);
        end

        // Response-to-decode latency with an empty queue.
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("lat_same_cycle", 32'(samp_dec_v), 32'(Byp));
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("lat_next_cycle", 32'(samp_dec_v), 32'(!Byp));

        // Randomized traffic against the model, with occasional mid-run resets.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                              : $urandom();
            cycle($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7);
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
